// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux8_scan_seq select sequencer.
//   state_e     : sequencer FSM state
//   sel_first   : first select position of a frame for a given bit order
//   sel_last    : last select position of a frame for a given bit order
//   presc_width : prescaler width needed to count 0..bit_cycles-1
package mux_scan_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    function automatic logic [2:0] sel_first(input bit msb_first);
        return msb_first ? 3'd7 : 3'd0;
    endfunction

    function automatic logic [2:0] sel_last(input bit msb_first);
        return msb_first ? 3'd0 : 3'd7;
    endfunction

    function automatic int unsigned presc_width(input int unsigned bit_cycles);
        return (bit_cycles <= 1) ? 1 : $clog2(bit_cycles);
    endfunction

endpackage

// File: rtl/mux8_scan_seq_if.sv
// Bus between the word source / mux and the select sequencer.
//   din, din_valid, din_ready : parallel word handshake
//   pause                     : freeze the running sequence
//   mux_i, mux_s              : registered mux data word and select
//   bit_stb, bit_last, busy   : serial framing
// master: the upstream/integrator side; slave: the sequencer.
interface mux8_scan_seq_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       pause;
    logic [7:0] mux_i;
    logic [2:0] mux_s;
    logic       bit_stb;
    logic       bit_last;
    logic       busy;

    modport master (
        output din, din_valid, pause,
        input  din_ready, mux_i, mux_s, bit_stb, bit_last, busy
    );

    modport slave (
        input  din, din_valid, pause,
        output din_ready, mux_i, mux_s, bit_stb, bit_last, busy
    );
endinterface

// File: rtl/bit_timer.sv
// Slot prescaler: counts 0..Cycles-1 while enabled, wraps on terminal count.
//   clk, rst_n : clock, async active-low reset
//   en_i       : advance the count this cycle
//   clr_i      : synchronous clear (wins over en_i)
//   cnt_o      : current count
//   tc_o       : count is at its terminal value
module bit_timer #(
    parameter int unsigned Cycles = 1,
    parameter int unsigned Width  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o,
    output logic             tc_o
);
    localparam logic [Width-1:0] TermCnt = Width'(Cycles - 1);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == TermCnt) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TermCnt);
endmodule

// File: rtl/mux8_scan_seq.sv
// Select sequencer for an external 8-to-1 mux. Accepts a word, registers it
// onto the mux data inputs, then walks the select through all eight positions,
// holding each for BIT_CYCLES cycles.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of mux8_scan_seq_if (handshake, mux drive, framing)
module mux8_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux8_scan_seq_if.slave        bus
);
    localparam int unsigned PrescW   = presc_width(BIT_CYCLES);
    localparam logic [2:0]  SelFirst = sel_first(MSB_FIRST);
    localparam logic [2:0]  SelLast  = sel_last(MSB_FIRST);

    state_e      state_q, state_d;
    logic [7:0]  mux_i_q, mux_i_d;
    logic [2:0]  mux_s_q, mux_s_d;

    logic [PrescW-1:0] presc;
    logic presc_tc;
    logic run, step_en, slot_end, frame_end, accept, din_ready;

    assign run       = (state_q == StRun);
    assign step_en   = run & ~bus.pause;
    assign slot_end  = step_en & presc_tc;
    assign frame_end = slot_end & (mux_s_q == SelLast);
    assign accept    = din_ready & bus.din_valid;

    bit_timer #(
        .Cycles (BIT_CYCLES),
        .Width  (PrescW)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (step_en),
        .clr_i (accept),
        .cnt_o (presc),
        .tc_o  (presc_tc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mux_i_q <= '0;
            mux_s_q <= '0;
        end else begin
            state_q <= state_d;
            mux_i_q <= mux_i_d;
            mux_s_q <= mux_s_d;
        end
    end

    // Next state and datapath
    always_comb begin
        state_d = state_q;
        mux_i_d = mux_i_q;
        mux_s_d = mux_s_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StRun;
            StRun:  if (frame_end && !accept) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (accept) begin
            mux_i_d = bus.din;
            mux_s_d = SelFirst;
        end else if (slot_end && (mux_s_q != SelLast)) begin
            // The step after the last slot is replaced by a reload or by idling.
            mux_s_d = MSB_FIRST ? mux_s_q - 3'd1 : mux_s_q + 3'd1;
        end
    end

    // Outputs
    always_comb begin
        din_ready    = (state_q == StIdle) | frame_end;
        bus.bit_stb  = step_en & (presc == '0);
        bus.bit_last = run & (mux_s_q == SelLast);
        bus.busy     = run;
    end

    assign bus.din_ready = din_ready;
    assign bus.mux_i     = mux_i_q;
    assign bus.mux_s     = mux_s_q;
endmodule

// File: tb/tb_mux8_scan_seq.sv
// Directed bench for mux8_scan_seq: one instance with BIT_CYCLES=1/MSB first,
// one with BIT_CYCLES=3/LSB first.
module tb_mux8_scan_seq;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    mux8_scan_seq_if bus_a ();
    mux8_scan_seq_if bus_b ();

    mux8_scan_seq #(.BIT_CYCLES(1), .MSB_FIRST(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    mux8_scan_seq #(.BIT_CYCLES(3), .MSB_FIRST(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    logic ser_a, ser_b;
    assign ser_a = bus_a.mux_i[bus_a.mux_s];
    assign ser_b = bus_b.mux_i[bus_b.mux_s];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to a new cycle; inputs are driven next, outputs sampled 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_a(input string tag);
        check_eq({tag, " a ready"}, bus_a.din_ready, 1);
        check_eq({tag, " a busy"},  bus_a.busy, 0);
        check_eq({tag, " a stb"},   bus_a.bit_stb, 0);
        check_eq({tag, " a last"},  bus_a.bit_last, 0);
        check_eq({tag, " a mux_i"}, bus_a.mux_i, 0);
        check_eq({tag, " a mux_s"}, bus_a.mux_s, 0);
    endtask

    task automatic check_reset_b(input string tag);
        check_eq({tag, " b ready"}, bus_b.din_ready, 1);
        check_eq({tag, " b busy"},  bus_b.busy, 0);
        check_eq({tag, " b stb"},   bus_b.bit_stb, 0);
        check_eq({tag, " b last"},  bus_b.bit_last, 0);
        check_eq({tag, " b mux_i"}, bus_b.mux_i, 0);
        check_eq({tag, " b mux_s"}, bus_b.mux_s, 0);
    endtask

    // Two words on dut_a: second presented from cycle chg with din_valid held.
    task automatic run_b2b(input logic [7:0] w0, input logic [7:0] w1, input int chg);
        cyc();
        bus_a.din = w0;
        bus_a.din_valid = 1'b1;
        #1;
        check_eq("b2b idle ready", bus_a.din_ready, 1);
        for (int i = 1; i <= 17; i++) begin
            cyc();
            if (i <= 8) begin
                bus_a.din_valid = (i >= chg);
                if (i >= chg) bus_a.din = w1;
            end else begin
                bus_a.din_valid = 1'b0;
            end
            #1;
            check_eq("b2b busy", bus_a.busy, (i <= 16));
            check_eq("b2b ready", bus_a.din_ready, (i == 8 || i >= 16));
            check_eq("b2b mux_i", bus_a.mux_i, (i <= 8) ? w0 : w1);
            check_eq("b2b mux_s", bus_a.mux_s, (i <= 8) ? 8 - i : (i <= 16 ? 16 - i : 0));
            if (i <= 16) check_eq("b2b stb", bus_a.bit_stb, 1);
        end
    endtask

    // One frame on dut_b, optionally with a 4-cycle pause during slot 4.
    task automatic run_slot(input logic [7:0] d, input bit pause_on);
        int eff;
        bit paused;
        cyc();
        bus_b.din = d;
        bus_b.din_valid = 1'b1;
        #1;
        check_eq("slot idle ready", bus_b.din_ready, 1);
        for (int i = 1; i <= (pause_on ? 29 : 25); i++) begin
            cyc();
            paused = pause_on && (i >= 14) && (i <= 17);
            bus_b.pause = paused;
            // Upstream offers a different word during the pause; it must be ignored.
            bus_b.din_valid = paused;
            bus_b.din = paused ? 8'h77 : d;
            if (!pause_on || i <= 14) eff = i - 1;
            else if (i <= 18) eff = 13;
            else eff = i - 5;
            #1;
            check_eq("slot busy", bus_b.busy, (eff < 24));
            check_eq("slot mux_i", bus_b.mux_i, d);
            if (eff < 24) begin
                check_eq("slot mux_s", bus_b.mux_s, eff / 3);
                check_eq("slot stb", bus_b.bit_stb, (eff % 3 == 0) && !paused);
                check_eq("slot last", bus_b.bit_last, (eff / 3 == 7));
                check_eq("slot ready", bus_b.din_ready, (eff == 23) && !paused);
                check_eq("slot serial", ser_b, d[eff / 3]);
            end else begin
                check_eq("slot end stb", bus_b.bit_stb, 0);
                check_eq("slot end last", bus_b.bit_last, 0);
                check_eq("slot end ready", bus_b.din_ready, 1);
            end
        end
        bus_b.pause = 1'b0;
        bus_b.din_valid = 1'b0;
    endtask

    int ser_tab [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        rst_n = 1'b0;
        bus_a.din = '0; bus_a.din_valid = 1'b0; bus_a.pause = 1'b0;
        bus_b.din = '0; bus_b.din_valid = 1'b0; bus_b.pause = 1'b0;
        #12;
        check_reset_a("rst");
        check_reset_b("rst");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Basic frame: A5, MSB first, one cycle per bit
        cyc();
        bus_a.din = 8'hA5;
        bus_a.din_valid = 1'b1;
        #1;
        check_eq("basic ready0", bus_a.din_ready, 1);
        check_eq("basic busy0", bus_a.busy, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            bus_a.din_valid = 1'b0;
            #1;
            check_eq("basic mux_s", bus_a.mux_s, 8 - i);
            check_eq("basic mux_i", bus_a.mux_i, 8'hA5);
            check_eq("basic stb", bus_a.bit_stb, 1);
            check_eq("basic busy", bus_a.busy, 1);
            check_eq("basic last", bus_a.bit_last, (i == 8));
            check_eq("basic ready", bus_a.din_ready, (i == 8));
            check_eq("basic serial", ser_a, ser_tab[i-1]);
        end
        cyc();
        #1;
        check_eq("basic idle busy", bus_a.busy, 0);
        check_eq("basic idle stb", bus_a.bit_stb, 0);
        check_eq("basic idle last", bus_a.bit_last, 0);
        check_eq("basic idle ready", bus_a.din_ready, 1);
        check_eq("basic hold mux_i", bus_a.mux_i, 8'hA5);
        check_eq("basic hold mux_s", bus_a.mux_s, 0);

        // Back-to-back FF then 00 with valid held throughout
        run_b2b(8'hFF, 8'h00, 1);
        // Upstream stall: second word raised at mux_s=5, must wait for frame end
        run_b2b(8'hC3, 8'h3C, 3);

        // Slot hold, then pause at mux_s=4
        run_slot(8'h01, 1'b0);
        run_slot(8'h10, 1'b1);

        // Async reset mid-frame at mux_s=3
        cyc();
        bus_b.din = 8'h96;
        bus_b.din_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            bus_b.din_valid = 1'b0;
        end
        #1;
        check_eq("arst pre mux_s", bus_b.mux_s, 3);
        check_eq("arst pre busy", bus_b.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_b("arst");
        cyc();
        rst_n = 1'b1;
        #1;
        check_eq("arst rel ready", bus_b.din_ready, 1);
        check_eq("arst rel busy", bus_b.busy, 0);
        bus_b.din = 8'h5A;
        bus_b.din_valid = 1'b1;
        cyc();
        bus_b.din_valid = 1'b0;
        #1;
        check_eq("arst new mux_i", bus_b.mux_i, 8'h5A);
        check_eq("arst new mux_s", bus_b.mux_s, 0);
        check_eq("arst new busy", bus_b.busy, 1);
        check_eq("arst new stb", bus_b.bit_stb, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
